// File: rtl/nl_sequencer_if.sv
// Command and response handshake bundle of the nonlinear-engine sequencer.
// master = command issuer / result consumer, slave = the sequencer itself.
interface nl_sequencer_if #(
    parameter int DW = 32,
    parameter int AW = 17
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [6*DW-1:0] cmd_dvec;
    logic [3*AW-1:0] cmd_avec;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [2:0]      rsp_idx;
    logic            rsp_last;

    modport master (
        output cmd_valid, cmd_op, cmd_dvec, cmd_avec, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dvec, cmd_avec, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
    );
endinterface

// File: rtl/nl_sequencer.sv
// Sequencer for the nonlinear engine: issue, wait for done, stream results.
// Optional WAIT abort counter enabled by defining NL_SEQ_TIMEOUT_EN.
module nl_sequencer #(
    parameter int DW = 32,
    parameter int AW = 17
`ifdef NL_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic            clk,
    input  logic            rst,
    nl_sequencer_if.slave   bus,
    output logic            o_nl_init_predict,
    output logic            o_nl_init_newlm,
    output logic            o_nl_init_update,
    output logic [6*DW-1:0] o_nl_dvec,
    output logic [3*AW-1:0] o_nl_avec,
    input  logic            i_nl_done_predict,
    input  logic            i_nl_done_newlm,
    input  logic            i_nl_done_update,
    input  logic [6*DW-1:0] i_nl_res,
    output logic            o_busy,
    output logic            o_err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;

    localparam logic [1:0] OP_PRED  = 2'd0;
    localparam logic [1:0] OP_NEWLM = 2'd1;
    localparam logic [1:0] OP_UPD   = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    logic [2:0]      r_state;
    logic [1:0]      r_op;
    logic [6*DW-1:0] r_dvec;
    logic [3*AW-1:0] r_avec;
    logic [DW-1:0]   r_res [6];
    logic [2:0]      r_ptr;
    logic            r_err;
    logic            r_init_p;
    logic            r_init_n;
    logic            r_init_u;
    logic            w_done;
    logic [2:0]      w_first;
    logic [2:0]      w_last;

`ifdef NL_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
`endif

    // Only the done of the issued op can complete WAIT.
    assign w_done = ((r_op == OP_PRED)  & i_nl_done_predict) |
                    ((r_op == OP_NEWLM) & i_nl_done_newlm)   |
                    ((r_op == OP_UPD)   & i_nl_done_update);

    assign w_first = (r_op == OP_PRED) ? 3'd1 : 3'd0;
    assign w_last  = (r_op == OP_UPD)  ? 3'd5 : 3'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_PRED;
            r_dvec   <= '0;
            r_avec   <= '0;
            r_ptr    <= '0;
            r_err    <= 1'b0;
            r_init_p <= 1'b0;
            r_init_n <= 1'b0;
            r_init_u <= 1'b0;
            for (int i = 0; i < 6; i++) r_res[i] <= '0;
`ifdef NL_SEQ_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_init_p <= 1'b0;
            r_init_n <= 1'b0;
            r_init_u <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_op == OP_ILL) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op     <= bus.cmd_op;
                            r_dvec   <= bus.cmd_dvec;
                            r_avec   <= bus.cmd_avec;
                            r_err    <= 1'b0;
                            r_init_p <= (bus.cmd_op == OP_PRED);
                            r_init_n <= (bus.cmd_op == OP_NEWLM);
                            r_init_u <= (bus.cmd_op == OP_UPD);
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef NL_SEQ_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_SETTLE;
`ifdef NL_SEQ_TIMEOUT_EN
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                S_SETTLE: begin
                    for (int i = 0; i < 6; i++)
                        r_res[i] <= i_nl_res[i*DW +: DW];
                    r_ptr   <= w_first;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (bus.rsp_ready) begin
                        if (r_ptr == w_last) r_state <= S_IDLE;
                        else r_ptr <= r_ptr + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE) & ~rst;
    assign bus.rsp_valid = (r_state == S_SEND);
    assign bus.rsp_data  = r_res[r_ptr];
    assign bus.rsp_idx   = r_ptr;
    assign bus.rsp_last  = bus.rsp_valid & (r_ptr == w_last);

    assign o_nl_init_predict = r_init_p;
    assign o_nl_init_newlm   = r_init_n;
    assign o_nl_init_update  = r_init_u;
    assign o_nl_dvec         = r_dvec;
    assign o_nl_avec         = r_avec;
    assign o_busy            = (r_state != S_IDLE);
    assign o_err             = r_err;
endmodule
